// File: rtl/trace_frame_pkg.sv
// Shared constants, state encoding and helpers for the trace frame collector.
package trace_frame_pkg;

  localparam int unsigned WORD_WIDTH      = 16;
  localparam int unsigned WORDS_PER_FRAME = 8;
  localparam int unsigned FRAME_WIDTH     = 128;
  localparam int unsigned POS_WIDTH       = 3;
  localparam int unsigned CNT_WIDTH       = 16;

  localparam logic [WORD_WIDTH-1:0] SYNC_HW_LO = 16'hFFFF;
  localparam logic [WORD_WIDTH-1:0] SYNC_HW_HI = 16'h7FFF;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    SEEN_FF = 2'd1,
    SYNCED  = 2'd2
  } state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sync_watchdog.sv
// Counts accepted words since the last full sync; flags the word that reaches 2^LOG2-1.
module sync_watchdog #(
  parameter int unsigned SYNC_TIMEOUT_LOG2 = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expire_c
);

  localparam int unsigned W = SYNC_TIMEOUT_LOG2;
  // Value held just before the expiring word: 2^W - 2.
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end
  end

  assign expire_c = tick && (count == LAST);

endmodule

// File: rtl/trace_frame_collector.sv
// TPIU full-sync aligner that assembles eight halfwords into a 128-bit frame.
// Optional statistics counters are built only when FRAME_STATS_EN is defined.
module trace_frame_collector
  import trace_frame_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT_LOG2 = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   WordAvail,
  input  logic [WORD_WIDTH-1:0]  WordIn,
  output logic                   FrAvail,
  output logic [FRAME_WIDTH-1:0] FrameOut,
  output logic                   Synced,
  output logic [CNT_WIDTH-1:0]   SyncCnt,
  output logic [CNT_WIDTH-1:0]   DropCnt
);

  localparam int unsigned          SHADOW_WORDS = WORDS_PER_FRAME - 1;
  localparam logic [POS_WIDTH-1:0] LAST_POS     = POS_WIDTH'(SHADOW_WORDS);

  state_t                                  state;
  state_t                                  stateNext;
  logic [POS_WIDTH-1:0]                    pos;
  logic [POS_WIDTH-1:0]                    posNext;
  logic [SHADOW_WORDS-1:0][WORD_WIDTH-1:0] shadow;
  logic                                    prevFF;
  logic                                    isLo;
  logic                                    isHi;
  logic                                    resync;
  logic                                    syncHit;
  logic                                    wdTick;
  logic                                    wdExpire_c;
  logic                                    store;
  logic                                    emit;

  assign isLo    = (WordIn == SYNC_HW_LO);
  assign isHi    = (WordIn == SYNC_HW_HI);
  assign resync  = (state == SYNCED) && prevFF && isHi;
  assign syncHit = WordAvail && (resync || ((state == SEEN_FF) && isHi));
  // A resync word restarts the watchdog rather than counting toward expiry.
  assign wdTick  = WordAvail && (state == SYNCED) && !resync;

  sync_watchdog #(
    .SYNC_TIMEOUT_LOG2(SYNC_TIMEOUT_LOG2)
  ) uWatchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (syncHit),
    .tick    (wdTick),
    .expire_c(wdExpire_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= UNSYNC;
      pos   <= '0;
    end else begin
      state <= stateNext;
      pos   <= posNext;
    end
  end

  // Priority inside SYNCED: resync, then watchdog expiry, then halfword-sync strip, then store.
  always_comb begin
    stateNext = state;
    posNext   = pos;
    store     = 1'b0;
    emit      = 1'b0;
    if (WordAvail) begin
      case (state)
        UNSYNC: begin
          if (isLo) stateNext = SEEN_FF;
        end
        SEEN_FF: begin
          if (isHi) begin
            stateNext = SYNCED;
            posNext   = '0;
          end else if (!isLo) begin
            stateNext = UNSYNC;
          end
        end
        SYNCED: begin
          if (resync) begin
            posNext = '0;
          end else if (wdExpire_c) begin
            stateNext = UNSYNC;
            posNext   = '0;
          end else if (!(isHi && (pos == '0))) begin
            if (pos == LAST_POS) begin
              emit    = 1'b1;
              posNext = '0;
            end else begin
              store   = 1'b1;
              posNext = pos + POS_WIDTH'(1);
            end
          end
        end
        default: begin
          stateNext = UNSYNC;
          posNext   = '0;
        end
      endcase
    end
  end

  // Frame datapath: shadow words, frame register, toggle strobe and sync flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow   <= '0;
      prevFF   <= 1'b0;
      Synced   <= 1'b0;
      FrAvail  <= 1'b0;
      FrameOut <= '0;
    end else begin
      Synced <= (stateNext == SYNCED);
      if (WordAvail) prevFF <= isLo;
      for (int i = 0; i < int'(SHADOW_WORDS); i++) begin
        if (store && (pos == POS_WIDTH'(i))) shadow[i] <= WordIn;
      end
      if (emit) begin
        FrameOut <= {WordIn, shadow};
        FrAvail  <= ~FrAvail;
      end
    end
  end

`ifdef FRAME_STATS_EN
  logic                 dropHit;
  logic [CNT_WIDTH-1:0] syncCntQ;
  logic [CNT_WIDTH-1:0] dropCntQ;

  // Only a resync with two or more words pending counts as a discarded frame.
  assign dropHit = WordAvail && resync && (pos >= POS_WIDTH'(2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncCntQ <= '0;
      dropCntQ <= '0;
    end else begin
      if (syncHit) syncCntQ <= satInc(syncCntQ);
      if (dropHit) dropCntQ <= satInc(dropCntQ);
    end
  end

  assign SyncCnt = syncCntQ;
  assign DropCnt = dropCntQ;
`else
  assign SyncCnt = '0;
  assign DropCnt = '0;
`endif

endmodule

// File: tb/tb_trace_frame_collector.sv
// Self-checking bench for trace_frame_collector against a queue-based reference model.
module tb_trace_frame_collector;

  localparam int unsigned WD_LOG2  = 4;
  localparam int          WD_LIMIT = (1 << WD_LOG2) - 1;

  logic         clk;
  logic         rst;
  logic         WordAvail;
  logic [15:0]  WordIn;
  logic         FrAvail;
  logic [127:0] FrameOut;
  logic         Synced;
  logic [15:0]  SyncCnt;
  logic [15:0]  DropCnt;

  int nTests;
  int nFail;

  // Reference model: mode 0=hunting, 1=seen FFFF, 2=aligned.
  int           mMode;
  int           mWd;
  int           mSync;
  int           mDrop;
  int           mToggles;
  bit           mLastFF;
  logic [15:0]  mQ[$];
  logic [127:0] mFrame;

  trace_frame_collector #(.SYNC_TIMEOUT_LOG2(WD_LOG2)) dut (
    .clk      (clk),
    .rst      (rst),
    .WordAvail(WordAvail),
    .WordIn   (WordIn),
    .FrAvail  (FrAvail),
    .FrameOut (FrameOut),
    .Synced   (Synced),
    .SyncCnt  (SyncCnt),
    .DropCnt  (DropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expCnt(input int v);
`ifdef FRAME_STATS_EN
    return (v > 65535) ? 16'hFFFF : 16'(v);
`else
    return (v >= 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  task automatic modelReset();
    mMode = 0; mWd = 0; mSync = 0; mDrop = 0; mToggles = 0;
    mLastFF = 1'b0; mQ.delete(); mFrame = '0;
  endtask

  task automatic modelStep(input logic [15:0] w);
    bit wasFF;
    wasFF   = mLastFF;
    mLastFF = (w == 16'hFFFF);
    case (mMode)
      0: if (w == 16'hFFFF) mMode = 1;
      1: begin
        if (w == 16'h7FFF) begin
          mMode = 2; mQ.delete(); mWd = 0; mSync++;
        end else if (w != 16'hFFFF) begin
          mMode = 0;
        end
      end
      default: begin
        if (wasFF && w == 16'h7FFF) begin
          if (mQ.size() >= 2) mDrop++;
          mQ.delete(); mWd = 0; mSync++;
        end else begin
          mWd++;
          if (mWd == WD_LIMIT) begin
            mMode = 0; mQ.delete();
          end else if (!(w == 16'h7FFF && mQ.size() == 0)) begin
            mQ.push_back(w);
            if (mQ.size() == 8) begin
              for (int i = 0; i < 8; i++) mFrame[16*i +: 16] = mQ[i];
              mToggles++;
              mQ.delete();
            end
          end
        end
      end
    endcase
  endtask

  // One strobe followed by one idle clock carrying junk that must be ignored.
  task automatic sendWord(input logic [15:0] w);
    @(negedge clk);
    WordAvail = 1'b1; WordIn = w;
    @(negedge clk);
    WordAvail = 1'b0; WordIn = 16'($urandom);
    modelStep(w);
  endtask

  task automatic test_reset();
    rst = 1'b0; WordAvail = 1'b0; WordIn = 16'hFFFF;
    modelReset();
    repeat (2) @(negedge clk);
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL reset_fravail got=%0b exp=0", FrAvail); end
    nTests++; if (FrameOut !== 128'h0) begin nFail++; $display("FAIL reset_frameout got=%h exp=0", FrameOut); end
    nTests++; if (Synced !== 1'b0) begin nFail++; $display("FAIL reset_synced got=%0b exp=0", Synced); end
    nTests++; if (SyncCnt !== 16'h0) begin nFail++; $display("FAIL reset_synccnt got=%h exp=0", SyncCnt); end
    nTests++; if (DropCnt !== 16'h0) begin nFail++; $display("FAIL reset_dropcnt got=%h exp=0", DropCnt); end
    rst = 1'b1;
  endtask

  task automatic test_acquire();
    sendWord(16'hFFFF);
    nTests++; if (Synced !== 1'b0) begin nFail++; $display("FAIL acq_synced_ff got=%0b exp=0", Synced); end
    sendWord(16'h7FFF);
    nTests++; if (Synced !== 1'b1) begin nFail++; $display("FAIL acq_synced got=%0b exp=1", Synced); end
    for (int i = 1; i <= 7; i++) sendWord(16'(i));
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL acq_early_toggle got=%0b exp=0", FrAvail); end
    sendWord(16'h0008);
    nTests++; if (FrAvail !== 1'b1) begin nFail++; $display("FAIL acq_toggle got=%0b exp=1", FrAvail); end
    nTests++; if (FrameOut !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
      nFail++; $display("FAIL acq_frame got=%h exp=00080007000600050004000300020001", FrameOut); end
    nTests++; if (SyncCnt !== expCnt(1)) begin nFail++; $display("FAIL acq_synccnt got=%h exp=%h", SyncCnt, expCnt(1)); end
  endtask

  task automatic test_halfword_sync();
    // FFFF lands at pos 0 and is then reclaimed by the resync without counting a drop.
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    sendWord(16'h7FFF);
    sendWord(16'h7FFF);
    for (int i = 0; i < 7; i++) sendWord(16'hA000 + 16'(i));
    nTests++; if (FrAvail !== 1'b1) begin nFail++; $display("FAIL hws_early_toggle got=%0b exp=1", FrAvail); end
    sendWord(16'hA007);
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL hws_toggle got=%0b exp=0", FrAvail); end
    nTests++; if (FrameOut !== 128'hA007_A006_A005_A004_A003_A002_A001_A000) begin
      nFail++; $display("FAIL hws_frame got=%h exp=A007A006A005A004A003A002A001A000", FrameOut); end
    nTests++; if (DropCnt !== expCnt(0)) begin nFail++; $display("FAIL hws_dropcnt got=%h exp=%h", DropCnt, expCnt(0)); end
    nTests++; if (SyncCnt !== expCnt(2)) begin nFail++; $display("FAIL hws_synccnt got=%h exp=%h", SyncCnt, expCnt(2)); end
  endtask

  task automatic test_mid_frame_resync();
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    sendWord(16'h1111);
    sendWord(16'h2222);
    sendWord(16'h3333);
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    nTests++; if (DropCnt !== expCnt(1)) begin nFail++; $display("FAIL mid_dropcnt got=%h exp=%h", DropCnt, expCnt(1)); end
    nTests++; if (SyncCnt !== expCnt(4)) begin nFail++; $display("FAIL mid_synccnt got=%h exp=%h", SyncCnt, expCnt(4)); end
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL mid_no_toggle got=%0b exp=0", FrAvail); end
    for (int i = 0; i < 8; i++) sendWord(16'hB000 + 16'(i));
    nTests++; if (FrAvail !== 1'b1) begin nFail++; $display("FAIL mid_toggle got=%0b exp=1", FrAvail); end
    nTests++; if (FrameOut !== 128'hB007_B006_B005_B004_B003_B002_B001_B000) begin
      nFail++; $display("FAIL mid_frame got=%h exp=B007B006B005B004B003B002B001B000", FrameOut); end
  endtask

  task automatic test_watchdog();
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    for (int i = 0; i < 14; i++) sendWord(16'hC000 + 16'(i));
    nTests++; if (Synced !== 1'b1) begin nFail++; $display("FAIL wd_synced_14 got=%0b exp=1", Synced); end
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL wd_toggle_8 got=%0b exp=0", FrAvail); end
    sendWord(16'hC00E);
    nTests++; if (Synced !== 1'b0) begin nFail++; $display("FAIL wd_synced_15 got=%0b exp=0", Synced); end
    for (int i = 0; i < 10; i++) sendWord(16'hC100 + 16'(i));
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL wd_unsync_toggle got=%0b exp=0", FrAvail); end
    nTests++; if (FrameOut !== 128'hC007_C006_C005_C004_C003_C002_C001_C000) begin
      nFail++; $display("FAIL wd_frame got=%h exp=C007C006C005C004C003C002C001C000", FrameOut); end
    sendWord(16'hFFFF);
    sendWord(16'h7FFF);
    nTests++; if (Synced !== 1'b1) begin nFail++; $display("FAIL wd_resync got=%0b exp=1", Synced); end
    nTests++; if (SyncCnt !== expCnt(6)) begin nFail++; $display("FAIL wd_synccnt got=%h exp=%h", SyncCnt, expCnt(6)); end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) sendWord(16'hD000 + 16'(i));
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    #1;
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL rmf_fravail got=%0b exp=0", FrAvail); end
    nTests++; if (FrameOut !== 128'h0) begin nFail++; $display("FAIL rmf_frameout got=%h exp=0", FrameOut); end
    nTests++; if (Synced !== 1'b0) begin nFail++; $display("FAIL rmf_synced got=%0b exp=0", Synced); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) sendWord(16'hE000 + 16'(i));
    nTests++; if (FrAvail !== 1'b0) begin nFail++; $display("FAIL rmf_after_toggle got=%0b exp=0", FrAvail); end
    nTests++; if (Synced !== 1'b0) begin nFail++; $display("FAIL rmf_after_synced got=%0b exp=0", Synced); end
    nTests++; if (SyncCnt !== 16'h0) begin nFail++; $display("FAIL rmf_synccnt got=%h exp=0", SyncCnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int unsigned r;
      logic [15:0] w;
      r = $urandom_range(0, 99);
      if (r < 9)       w = 16'hFFFF;
      else if (r < 18) w = 16'h7FFF;
      else             w = 16'($urandom);
      sendWord(w);
      nTests++; if (Synced !== (mMode == 2)) begin nFail++; $display("FAIL rnd_synced n=%0d got=%0b exp=%0b", n, Synced, mMode == 2); end
      nTests++; if (FrAvail !== mToggles[0]) begin nFail++; $display("FAIL rnd_fravail n=%0d got=%0b exp=%0b", n, FrAvail, mToggles[0]); end
      nTests++; if (FrameOut !== mFrame) begin nFail++; $display("FAIL rnd_frame n=%0d got=%h exp=%h", n, FrameOut, mFrame); end
      nTests++; if (SyncCnt !== expCnt(mSync)) begin nFail++; $display("FAIL rnd_synccnt n=%0d got=%h exp=%h", n, SyncCnt, expCnt(mSync)); end
      nTests++; if (DropCnt !== expCnt(mDrop)) begin nFail++; $display("FAIL rnd_dropcnt n=%0d got=%h exp=%h", n, DropCnt, expCnt(mDrop)); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    nTests = 0;
    nFail  = 0;
    test_reset();
    test_acquire();
    test_halfword_sync();
    test_mid_frame_resync();
    test_watchdog();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
